// File: rtl/audio_pkg.sv
// Shared types for the audio sample player: source-select modes, transfer FSM states
// and the default sample width.
package audio_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_ROM  = 2'd1,
        MODE_MIX  = 2'd2,
        MODE_MUTE = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_XFER   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 24;

endpackage

// File: rtl/sample_addr_counter.sv
// Wrapping ROM address counter: counts 0..DEPTH-1 on en and pulses wrap for one
// cycle together with the return to address 0.
module sample_addr_counter #(
    parameter int DEPTH  = 48000,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Address register with single-cycle wrap flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr <= {ADDR_W{1'b0}};
            wrap <= 1'b0;
        end else if (en) begin
            if (addr == LAST_ADDR) begin
                addr <= {ADDR_W{1'b0}};
                wrap <= 1'b1;
            end else begin
                addr <= addr + ADDR_W'(1);
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/audio_sample_player.sv
// Per-slot audio source (passthrough / ROM / mix / mute) between codec FIFOs and DAC.
// Optional VOLUME_EN macro adds a vol[2:0] port for arithmetic right-shift attenuation.
module audio_sample_player
    import audio_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 48000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        mode,
    input  logic              read_ready,
    input  logic              write_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    input  logic [DATA_W-1:0] rom_data,
`ifdef VOLUME_EN
    input  logic [2:0]        vol,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              loop_done
);

    state_t            state_r;
    state_t            state_nxt_s;
    mode_t             mode_s;
    logic              capture_s;
    logic              adv_s;
    logic [2:0]        vol_s;
    logic [DATA_W-1:0] src_l_s;
    logic [DATA_W-1:0] src_r_s;
    logic [DATA_W-1:0] out_l_s;
    logic [DATA_W-1:0] out_r_s;

    // Average of two samples in DATA_W+1 bits, so the sum can never overflow
    function automatic logic [DATA_W-1:0] mix_half(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        return sum[DATA_W:1];
    endfunction

    assign mode_s = mode_t'(mode);

`ifdef VOLUME_EN
    assign vol_s = vol;
`else
    assign vol_s = 3'd0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a capture happens only from IDLE with both FIFOs ready
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (read_ready && write_ready) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_XFER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_XFER:   state_nxt_s = ST_SETTLE;
            ST_SETTLE: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // The address steps on the capture edge, so the new ROM word lands during SETTLE
    assign adv_s = capture_s && ((mode_s == MODE_ROM) || (mode_s == MODE_MIX));

    sample_addr_counter #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (adv_s),
        .addr    (rom_addr),
        .wrap    (loop_done)
    );

    // Source select followed by volume shift
    always_comb begin
        src_l_s = {DATA_W{1'b0}};
        src_r_s = {DATA_W{1'b0}};
        case (mode_s)
            MODE_PASS: begin
                src_l_s = readdata_left;
                src_r_s = readdata_right;
            end
            MODE_ROM: begin
                src_l_s = rom_data;
                src_r_s = rom_data;
            end
            MODE_MIX: begin
                src_l_s = mix_half(readdata_left, rom_data);
                src_r_s = mix_half(readdata_right, rom_data);
            end
            MODE_MUTE: begin
                src_l_s = {DATA_W{1'b0}};
                src_r_s = {DATA_W{1'b0}};
            end
            default: begin
                src_l_s = {DATA_W{1'b0}};
                src_r_s = {DATA_W{1'b0}};
            end
        endcase
        out_l_s = DATA_W'($signed(src_l_s) >>> vol_s);
        out_r_s = DATA_W'($signed(src_r_s) >>> vol_s);
    end

    // Handshake pulses and sample outputs, updated only on a capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read            <= 1'b0;
            write           <= 1'b0;
            writedata_left  <= {DATA_W{1'b0}};
            writedata_right <= {DATA_W{1'b0}};
        end else begin
            read  <= capture_s;
            write <= capture_s;
            if (capture_s) begin
                writedata_left  <= out_l_s;
                writedata_right <= out_r_s;
            end else begin
                writedata_left  <= writedata_left;
                writedata_right <= writedata_right;
            end
        end
    end

endmodule
